// File: rtl/ram_march_bist.sv
// March C- BIST initiator for a single-port synchronous RAM (registered, read-first dout).
// Define RAM_BIST_FAIL_LOG_EN to build the first-failure log (fail_addr/fail_data/fail_elem).
module ram_march_bist #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ADDRESS_WIDTH = 4,
   parameter int unsigned DEPTH         = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic                     ram_we,
   output logic [ADDRESS_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0]    ram_din,
   input  logic [DATA_WIDTH-1:0]    ram_dout,
   output logic [ADDRESS_WIDTH-1:0] fail_addr,
   output logic [DATA_WIDTH-1:0]    fail_data,
   output logic [2:0]               fail_elem
);

   typedef enum logic [3:0] {
      StIdle, StM0, StM1, StM2, StM3, StM4, StM5, StFlush, StDone
   } state_e;

   localparam logic [ADDRESS_WIDTH-1:0] AddrLast = ADDRESS_WIDTH'(DEPTH - 1);
   localparam logic [ADDRESS_WIDTH-1:0] AddrOne  = ADDRESS_WIDTH'(1);
   localparam logic [DATA_WIDTH-1:0]    Ones     = '1;

   state_e                     state_q, state_d, next_st;
   logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
   logic                       phase_q, phase_d;
   logic                       fail_q, fail_d;
   logic                       pass_q, pass_d;
   logic                       rd_valid_q, rd_exp_q;
   logic                       is_elem, two_phase, descending, wr_ones, exp_ones, next_desc;
   logic                       read_cycle, addr_end, mismatch;

   // Per-element attributes: direction, read/write patterns and successor.
   always_comb begin
      is_elem    = 1'b1;
      two_phase  = 1'b0;
      descending = 1'b0;
      wr_ones    = 1'b0;
      exp_ones   = 1'b0;
      next_st    = StIdle;
      next_desc  = 1'b0;
      unique case (state_q)
         StM0: next_st = StM1;
         StM1: begin
            two_phase = 1'b1;
            wr_ones   = 1'b1;
            next_st   = StM2;
         end
         StM2: begin
            two_phase = 1'b1;
            exp_ones  = 1'b1;
            next_st   = StM3;
            next_desc = 1'b1;
         end
         StM3: begin
            two_phase  = 1'b1;
            descending = 1'b1;
            wr_ones    = 1'b1;
            next_st    = StM4;
            next_desc  = 1'b1;
         end
         StM4: begin
            two_phase  = 1'b1;
            descending = 1'b1;
            exp_ones   = 1'b1;
            next_st    = StM5;
         end
         StM5: next_st = StFlush;
         default: is_elem = 1'b0;
      endcase
   end

   assign addr_end = descending ? (addr_q == '0) : (addr_q == AddrLast);
   assign mismatch = rd_valid_q && (ram_dout != (rd_exp_q ? Ones : '0));

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      phase_d    = phase_q;
      pass_d     = pass_q;
      fail_d     = fail_q | mismatch;
      ram_we     = 1'b0;
      ram_addr   = '0;
      ram_din    = '0;
      read_cycle = 1'b0;
      if (is_elem) begin
         // Two-phase elements: phase 0 reads, phase 1 writes the same address.
         read_cycle = two_phase ? ~phase_q : (state_q == StM5);
         ram_we     = two_phase ? phase_q : (state_q == StM0);
         ram_addr   = addr_q;
         ram_din    = (ram_we && wr_ones) ? Ones : '0;
         if (two_phase) begin
            phase_d = ~phase_q;
         end
         if (!two_phase || phase_q) begin
            if (addr_end) begin
               state_d = next_st;
               addr_d  = next_desc ? AddrLast : '0;
            end else if (descending) begin
               addr_d = addr_q - AddrOne;
            end else begin
               addr_d = addr_q + AddrOne;
            end
         end
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  state_d = StM0;
                  addr_d  = '0;
                  phase_d = 1'b0;
                  fail_d  = 1'b0;
                  pass_d  = 1'b0;
               end
            end
            StFlush: begin
               state_d = StDone;
               pass_d  = ~fail_d;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         phase_q    <= 1'b0;
         fail_q     <= 1'b0;
         pass_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_exp_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         phase_q    <= phase_d;
         fail_q     <= fail_d;
         pass_q     <= pass_d;
         rd_valid_q <= read_cycle;
         rd_exp_q   <= exp_ones;
      end
   end

   assign busy = is_elem || (state_q == StFlush);
   assign done = (state_q == StDone);
   assign pass = pass_q;

`ifdef RAM_BIST_FAIL_LOG_EN
   logic [ADDRESS_WIDTH-1:0] rd_addr_q, fail_addr_q;
   logic [DATA_WIDTH-1:0]    fail_data_q;
   logic [2:0]               rd_elem_q, fail_elem_q, elem_num;

   always_comb begin
      elem_num = 3'd0;
      case (state_q)
         StM1:    elem_num = 3'd1;
         StM2:    elem_num = 3'd2;
         StM3:    elem_num = 3'd3;
         StM4:    elem_num = 3'd4;
         StM5:    elem_num = 3'd5;
         default: elem_num = 3'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_addr_q   <= '0;
         rd_elem_q   <= '0;
         fail_addr_q <= '0;
         fail_data_q <= '0;
         fail_elem_q <= '0;
      end else begin
         rd_addr_q <= ram_addr;
         rd_elem_q <= elem_num;
         if (state_q == StIdle && start) begin
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_elem_q <= '0;
         end else if (mismatch && !fail_q) begin
            fail_addr_q <= rd_addr_q;
            fail_data_q <= ram_dout;
            fail_elem_q <= rd_elem_q;
         end
      end
   end

   assign fail_addr = fail_addr_q;
   assign fail_data = fail_data_q;
   assign fail_elem = fail_elem_q;
`else
   assign fail_addr = '0;
   assign fail_data = '0;
   assign fail_elem = '0;
`endif

endmodule

// File: tb/tb_ram_march_bist.sv
// Directed bench for ram_march_bist driving a behavioural RAM with injectable faults.
module tb_ram_march_bist;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       busy, done, pass;
   logic       ram_we;
   logic [3:0] ram_addr;
   logic [7:0] ram_din;
   logic [7:0] ram_dout;
   logic [3:0] fail_addr;
   logic [7:0] fail_data;
   logic [2:0] fail_elem;

   int n_cmp = 0;
   int n_err = 0;
   int fault_mode = 0;  // 0 none, 1 stuck-at-1 bit3 @5, 2 write@2 inverts @9

   logic [7:0] mem [0:15];
   logic       log_we   [0:399];
   logic [3:0] log_addr [0:399];
   logic [7:0] log_din  [0:399];

   ram_march_bist #(
      .DATA_WIDTH    (8),
      .ADDRESS_WIDTH (4),
      .DEPTH         (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout),
      .fail_addr (fail_addr),
      .fail_data (fail_data),
      .fail_elem (fail_elem)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      ram_dout <= mem[ram_addr] | ((fault_mode == 1 && ram_addr == 4'd5) ? 8'h08 : 8'h00);
      if (ram_we) begin
         mem[ram_addr] <= ram_din;
         if (fault_mode == 2 && ram_addr == 4'd2) mem[9] <= ~mem[9];
      end
   end

   task automatic run_test(input bit hold, output int nbusy, output logic done_seen,
                           output logic pass_seen);
      start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      nbusy = 0;
      while (busy === 1'b1 && nbusy < 400) begin
         log_we[nbusy]   = ram_we;
         log_addr[nbusy] = ram_addr;
         log_din[nbusy]  = ram_din;
         nbusy++;
         @(posedge clk);
         #1;
      end
      done_seen = done;
      pass_seen = pass;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, done, pass, ram_we} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b, want 0000", {busy, done, pass, ram_we});
      end
      n_cmp++;
      if ({ram_addr, ram_din} !== 12'h000) begin
         n_err++;
         $display("FAIL reset_port: got %h, want 000", {ram_addr, ram_din});
      end
      n_cmp++;
      if ({fail_addr, fail_data, fail_elem} !== 15'h0) begin
         n_err++;
         $display("FAIL reset_log: got %h, want 0", {fail_addr, fail_data, fail_elem});
      end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL idle_after_reset: busy got %b, want 0", busy);
      end
   endtask

   task automatic test_fault_free();
      int   nb, bad;
      logic d, p;
      fault_mode = 0;
      run_test(1'b0, nb, d, p);
      n_cmp++;
      if (nb !== 161) begin
         n_err++;
         $display("FAIL ff_busy_len: got %0d, want 161", nb);
      end
      n_cmp++;
      if (d !== 1'b1) begin
         n_err++;
         $display("FAIL ff_done: got %b, want 1", d);
      end
      n_cmp++;
      if (p !== 1'b1) begin
         n_err++;
         $display("FAIL ff_pass: got %b, want 1", p);
      end
      bad = -1;
      for (int i = 0; i < 16; i++) begin
         if (bad < 0 && (log_we[i] !== 1'b1 || log_addr[i] !== 4'(i) || log_din[i] !== 8'h00))
            bad = i;
      end
      n_cmp++;
      if (bad !== -1) begin
         n_err++;
         $display("FAIL m0_seq: first bad cycle got %0d, want -1", bad);
      end
      bad = -1;
      for (int j = 0; j < 32; j++) begin
         if (bad < 0 && (log_addr[80+j] !== 4'(15 - j / 2) || log_we[80+j] !== 1'(j % 2)))
            bad = j;
         if (bad < 0 && (j % 2) == 1 && log_din[80+j] !== 8'hFF) bad = j;
      end
      n_cmp++;
      if (bad !== -1) begin
         n_err++;
         $display("FAIL m3_seq: first bad step got %0d, want -1", bad);
      end
      bad = -1;
      for (int i = 0; i < 16; i++) if (bad < 0 && mem[i] !== 8'h00) bad = i;
      n_cmp++;
      if (bad !== -1) begin
         n_err++;
         $display("FAIL ram_zero: first nonzero addr got %0d, want -1", bad);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({done, pass} !== 2'b01) begin
         n_err++;
         $display("FAIL done_pulse_pass_hold: got %b, want 01", {done, pass});
      end
   endtask

   task automatic test_stuck_at();
      int   nb;
      logic d, p;
      fault_mode = 1;
      run_test(1'b0, nb, d, p);
      n_cmp++;
      if ({d, p} !== 2'b10) begin
         n_err++;
         $display("FAIL sa1_verdict: done,pass got %b, want 10", {d, p});
      end
      n_cmp++;
`ifdef RAM_BIST_FAIL_LOG_EN
      if ({fail_addr, fail_data, fail_elem} !== {4'd5, 8'h08, 3'd1}) begin
         n_err++;
         $display("FAIL sa1_log: got %h, want %h", {fail_addr, fail_data, fail_elem},
                  {4'd5, 8'h08, 3'd1});
      end
`else
      if ({fail_addr, fail_data, fail_elem} !== 15'h0) begin
         n_err++;
         $display("FAIL sa1_log_tied: got %h, want 0", {fail_addr, fail_data, fail_elem});
      end
`endif
      @(posedge clk);
      #1;
      fault_mode = 0;
   endtask

   task automatic test_coupling();
      int   nb;
      logic d, p;
      fault_mode = 2;
      run_test(1'b0, nb, d, p);
      n_cmp++;
      if ({d, p} !== 2'b10) begin
         n_err++;
         $display("FAIL cf_verdict: done,pass got %b, want 10", {d, p});
      end
      n_cmp++;
`ifdef RAM_BIST_FAIL_LOG_EN
      if ({fail_addr, fail_data, fail_elem} !== {4'd9, 8'hFF, 3'd1}) begin
         n_err++;
         $display("FAIL cf_log: got %h, want %h", {fail_addr, fail_data, fail_elem},
                  {4'd9, 8'hFF, 3'd1});
      end
`else
      if (fail_addr !== 4'd0) begin
         n_err++;
         $display("FAIL cf_log_tied: fail_addr got %0d, want 0", fail_addr);
      end
`endif
      @(posedge clk);
      #1;
      fault_mode = 0;
   endtask

   task automatic test_back_to_back();
      int   nb;
      logic d, p;
      run_test(1'b1, nb, d, p);
      n_cmp++;
      if ({nb, d, p} !== {32'd161, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL hold_run1: len,done,pass got %0d,%b,%b, want 161,1,1", nb, d, p);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         n_err++;
         $display("FAIL hold_gap: busy,done got %b, want 00", {busy, done});
      end
      run_test(1'b1, nb, d, p);
      start = 1'b0;
      n_cmp++;
      if ({nb, d, p} !== {32'd161, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL hold_run2: len,done,pass got %0d,%b,%b, want 161,1,1", nb, d, p);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_mid_reset();
      int   nb;
      logic d, p;
      fault_mode = 2;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL mid_busy: got %b, want 1", busy);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, pass, ram_we, ram_addr, ram_din} !== 16'h0) begin
         n_err++;
         $display("FAIL async_reset: got %h, want 0", {busy, done, pass, ram_we, ram_addr, ram_din});
      end
      n_cmp++;
      if ({fail_addr, fail_data, fail_elem} !== 15'h0) begin
         n_err++;
         $display("FAIL async_reset_log: got %h, want 0", {fail_addr, fail_data, fail_elem});
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      fault_mode = 0;
      @(posedge clk);
      #1;
      run_test(1'b0, nb, d, p);
      n_cmp++;
      if ({nb, d, p} !== {32'd161, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL post_reset_run: len,done,pass got %0d,%b,%b, want 161,1,1", nb, d, p);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      clk   = 1'b0;
      rst_n = 1'b0;
      start = 1'b0;
      test_reset();
      test_fault_free();
      test_stuck_at();
      test_coupling();
      test_back_to_back();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ram_march_bist.md
# ram_march_bist

Built-in self-test initiator for the team's single-port synchronous RAM (`sync_ram` or any RAM with the same port protocol). On a `start` pulse it drives the RAM's `we`/`addr`/`din` port through a complete March C- sequence and checks every word returned on `dout`. It reports a single pass/fail verdict, with optional first-failure logging. It sits beside the RAM instance and owns the RAM port while `busy` is high; a system-side mux, outside this block, selects between functional traffic and this block.

## Interface
- `DATA_WIDTH`, 8, RAM word width.
- `ADDRESS_WIDTH`, 4, RAM address width.
- `DEPTH`, 16, number of words tested; legal range 2..2^ADDRESS_WIDTH.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a test; sampled only in IDLE.
- `busy`  out  1  test in progress; RAM port is owned by this block.
- `done`  out  1  one-cycle pulse at test end.
- `pass`  out  1  verdict of the last completed test; held until the next `start`.
- `ram_we`  out  1  to RAM `we`.
- `ram_addr`  out  ADDRESS_WIDTH  to RAM `addr`.
- `ram_din`  out  DATA_WIDTH  to RAM `din`.
- `ram_dout`  in  DATA_WIDTH  from RAM `dout`; registered, read-first, one-cycle latency.
- `fail_addr`  out  ADDRESS_WIDTH  address of the first mismatch.
- `fail_data`  out  DATA_WIDTH  word observed at the first mismatch.
- `fail_elem`  out  3  March element (1–5) of the first mismatch.

## Operation
- FSM states: IDLE, M0, M1, M2, M3, M4, M5, FLUSH, DONE.
  - IDLE→M0 on `start`.
  - Each element exits to the next when its address counter finishes.
  - M5→FLUSH→DONE→IDLE unconditionally.
- Patterns: "0" is all-zeros; "1" is all-ones (DATA_WIDTH bits).
- Element sequence:
  - M0: ascending, w0.
  - M1: ascending, (r0, w1).
  - M2: ascending, (r1, w0).
  - M3: descending, (r0, w1).
  - M4: descending, (r1, w0).
  - M5: ascending, r0.
- Address counter: ascending runs 0..DEPTH-1; descending runs DEPTH-1..0. Addresses ≥ DEPTH are never driven.
- Read-write elements take 2 cycles per address:
  - Cycle A: `ram_addr`=a, `ram_we`=0.
  - Cycle B: `ram_addr`=a, `ram_we`=1, `ram_din`=write pattern.
- Compare: in the cycle after any read cycle, `ram_dout` is compared against the expected pattern. The expected pattern and address are pipelined one stage with the read. FLUSH exists only to compare the final M5 read.
- Any mismatch sets a sticky fail flag. The test always runs to completion; there is no early abort.
- DONE: `done`=1 and `pass`=!fail for this run. `start` is ignored in DONE and while `busy`.
- Outside M0–M5: `ram_we`=0, `ram_addr`=0, `ram_din`=0.
- `rst_n` low at any time, including mid-test, forces all state to reset immediately. No partial verdict is kept; RAM contents are left undefined.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0, `fail_addr`=0, `fail_data`=0, `fail_elem`=0. FSM resets to IDLE.
- `start` high at edge E0: `busy` and the first M0 write are present from E0 onward.
- `busy` stays high for exactly 10·DEPTH+1 cycles: M0 DEPTH, M1–M4 2·DEPTH each, M5 DEPTH, FLUSH 1. That is 161 cycles at DEPTH=16.
- `done` and the updated `pass` appear in the first cycle after `busy` falls. Earliest re-start is the cycle after `done`.
- `start` clears `pass` and the fail log on E0.

## Configuration
- `RAM_BIST_FAIL_LOG_EN` defined: on the first mismatch of a run, capture `fail_addr`, `fail_data` and `fail_elem`. Later mismatches in the same run do not overwrite them; they hold until the next `start` or reset.
- Not defined: the logging registers are not built; `fail_addr`, `fail_data` and `fail_elem` are tied to 0. Verdict logic is unchanged.

## Test plan
- Fault-free RAM, DEPTH=16: one-cycle `start` → `busy` for 161 cycles, then `done` for one cycle, `pass`=1, every RAM word 0x00.
- Port-sequence check: in M0, `ram_we`=1 with `ram_addr` 0..15 on consecutive cycles and `ram_din`=0x00. In M3, addresses run 15,15,14,14,…,0,0 with `ram_we` alternating 0,1 and `ram_din`=0xFF on write cycles.
- Stuck-at-1 on bit 3 of address 5: `pass`=0. With the macro defined: `fail_addr`=5, `fail_data`=0x08, `fail_elem`=1.
- Coupling fault (a write to address 2 inverts address 9), macro defined → `pass`=0 and `fail_addr`=9.
- `start` held high through a whole run → extra pulses during `busy`/DONE are ignored; the second run begins in the cycle after `done` and lasts 161 cycles.
- `rst_n` low at cycle 50 of a run → all outputs take reset values asynchronously. After release, a new `start` produces a full 161-cycle run with `pass`=1.
